rgb2grey_pipe: RTL
==================

# rgb2grey_pipe

- Parametrised, pipelined successor to the camera-path greyscale stage.
- Converts each RGB pixel to luma using BT.601 integer weights, optionally thresholds it to binary, and replicates the result onto all three output channels.
- Mode and threshold are latched only at frame start, so one frame never mixes modes.
- Sits between the Bayer-to-RGB converter and the SDRAM write FIFO, and carries the pixel-valid strobe through a fixed-latency pipeline.

## Interface
- DATA_W, 12 — width of each colour channel and of luma.
- THRESH_DEFAULT, 2000 — threshold used after reset, until the first frame start.
- STAT_LOG2, 16 — log2 of the number of pixels averaged for the auto-threshold.
- iCLK  in  1  — pixel clock; all logic is on the rising edge.
- iRST_N  in  1  — synchronous, active-low reset.
- iFVAL  in  1  — frame valid; the frame starts on a 0→1 edge and ends on a 1→0 edge.
- iDVAL  in  1  — pixel valid for iRed/iGreen/iBlue.
- iRed, iGreen, iBlue  in  DATA_W each  — input pixel.
- iGREY_SW  in  1  — greyscale mode request.
- iBIN_SW  in  1  — binary mode request; it only has effect together with iGREY_SW.
- iTHRESH  in  DATA_W  — manual binary threshold.
- oRed, oGreen, oBlue  out  DATA_W each  — output pixel.
- oDVAL  out  1  — output pixel valid.
- oFRAME_CNT  out  16  — number of completed frames; wraps at 65535→0.
- oIN_FRAME  out  1  — high while the FSM is in IN_FRAME.

## Operation

**FSM**
- States: WAIT_FRAME and IN_FRAME. The reset state is WAIT_FRAME.
- A registered copy of iFVAL gives edge detection.
- WAIT_FRAME → IN_FRAME when iFVAL=1 and prev=0. On that cycle the block latches:
  - grey_l ← iGREY_SW
  - bin_l ← iGREY_SW & iBIN_SW
  - thr_l ← active threshold
- IN_FRAME → WAIT_FRAME when iFVAL=0 and prev=1. On that cycle oFRAME_CNT increments.
- Switch or iTHRESH changes mid-frame are ignored until the next frame start.

**Pixels**
- Pixels are processed whenever iDVAL=1, in either state, using the latched modes.
- Stage 1 registers the products 77·R, 150·G and 29·B, each DATA_W+8 bits.
- Stage 2 computes luma = (sum + 128) >> 8.
  - The result is clamped to 2^DATA_W−1; the clamp is not reachable with these weights but is still required.
  - The raw inputs are delayed alongside.
- Stage 3 selects the output:
  - grey_l=0: delayed input passed through unchanged.
  - grey_l=1, bin_l=0: luma on all three channels.
  - bin_l=1: all channels = 0 if luma > thr_l, else 2^DATA_W−1. Luma equal to the threshold gives full scale.
- iDVAL is delayed 3 stages to oDVAL. When oDVAL=0 the output data holds its last value.

**Reset**
- Every output, every pipeline register, the FSM and the counters clear on the first edge with iRST_N=0.
- oDVAL=0, all data outputs 0, oFRAME_CNT=0, oIN_FRAME=0.
- grey_l=0, bin_l=0, thr_l=THRESH_DEFAULT.
- A reset mid-frame discards in-flight pixels.
- After reset release, a frame already in progress (iFVAL=1) is not treated as started; the block waits for the next 0→1 edge.

## Timing
- Latency from iDVAL to oDVAL is exactly 3 cycles, identical in all modes. Throughput is 1 pixel per cycle.
- Mode, threshold and oIN_FRAME take effect on the cycle after the iFVAL rising edge.
  - Pixels presented on the edge cycle itself already use the new modes, because stage 3 sees the latched values 2 cycles later.
- oFRAME_CNT updates on the cycle after the iFVAL falling edge.
- If the iFVAL edge and iDVAL coincide, the pixel is processed normally.

## Configuration
Macro: RGB2GREY_AUTO_THRESH_EN.

**Defined:**
- During IN_FRAME, accumulate stage-2 luma of the first 2^STAT_LOG2 valid pixels. The accumulator is DATA_W+STAT_LOG2 bits, and counting stops once the count saturates.
- At frame end, if the count reached 2^STAT_LOG2, auto_thr ← acc >> STAT_LOG2. Otherwise auto_thr is unchanged.
- The accumulator and the count clear at every frame start.
- The active threshold is auto_thr, which resets to THRESH_DEFAULT; iTHRESH is ignored.

**Undefined:**
- The active threshold is iTHRESH.
- The accumulator and auto_thr logic are absent.

## Test plan
- **Reset:** hold iRST_N=0 for 2 cycles with iDVAL=1 → oDVAL=0, outputs 0, oFRAME_CNT=0.
- **Passthrough:** iGREY_SW=0; R=100, G=200, B=300 with iDVAL at cycle t → oDVAL=1 at t+3 with the same values.
- **Grey:** iGREY_SW=1, latched by a frame start; R=G=B=4095 → all outputs 4095. R=1000, G=0, B=0 → all outputs 301.
- **Binary:** iGREY_SW=iBIN_SW=1, iTHRESH=2000:
  - luma 2001 → 0/0/0
  - luma 2000 → 4095/4095/4095
  - toggling iBIN_SW mid-frame changes nothing until the next iFVAL rise.
- **Frames:** 3 iFVAL pulses → oFRAME_CNT=3. Reset mid-frame → count 0, and the next frame is counted only after a fresh rising edge.
- **Auto-threshold (macro defined, STAT_LOG2=2):**
  - frame of 4 pixels with luma 100/200/300/400 → next frame thr=250
  - frame with 3 pixels → thr unchanged

Source files
------------

// File: rtl/rgb2grey_pipe.sv
// BT.601 RGB-to-luma pipeline (3 stages) with frame-latched grey/binary modes.
// Optional auto-threshold from per-frame luma average: RGB2GREY_AUTO_THRESH_EN.
module rgb2grey_pipe #(
   parameter int DATA_W         = 12,
   parameter int THRESH_DEFAULT = 2000,
   parameter int STAT_LOG2      = 16
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iFVAL,
   input  logic              iDVAL,
   input  logic [DATA_W-1:0] iRed,
   input  logic [DATA_W-1:0] iGreen,
   input  logic [DATA_W-1:0] iBlue,
   input  logic              iGREY_SW,
   input  logic              iBIN_SW,
   input  logic [DATA_W-1:0] iTHRESH,
   output logic [DATA_W-1:0] oRed,
   output logic [DATA_W-1:0] oGreen,
   output logic [DATA_W-1:0] oBlue,
   output logic              oDVAL,
   output logic [15:0]       oFRAME_CNT,
   output logic              oIN_FRAME
);

   localparam int PW = DATA_W + 8;
   localparam int SW = DATA_W + 10;
   localparam logic [DATA_W-1:0] MAXV    = '1;
   localparam logic [DATA_W-1:0] THR_RST = DATA_W'(THRESH_DEFAULT);

   typedef enum logic {
      WAIT_FRAME = 1'b0,
      IN_FRAME   = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   w_start;
   logic   w_end;
   logic   r_fval_prev;
   logic   w_rise;
   logic   w_fall;

   logic              r_grey_l;
   logic              r_bin_l;
   logic [DATA_W-1:0] r_thr_l;
   logic [DATA_W-1:0] w_thr_act;

   logic              r_dv1;
   logic [PW-1:0]     r_pr;
   logic [PW-1:0]     r_pg;
   logic [PW-1:0]     r_pb;
   logic [DATA_W-1:0] r_r1;
   logic [DATA_W-1:0] r_g1;
   logic [DATA_W-1:0] r_b1;

   logic [SW-1:0]     w_sum;
   logic [DATA_W+1:0] w_luma_w;
   logic [DATA_W-1:0] w_luma;

   logic              r_dv2;
   logic [DATA_W-1:0] r_luma2;
   logic [DATA_W-1:0] r_r2;
   logic [DATA_W-1:0] r_g2;
   logic [DATA_W-1:0] r_b2;

   logic [DATA_W-1:0] w_r3;
   logic [DATA_W-1:0] w_g3;
   logic [DATA_W-1:0] w_b3;
   logic [DATA_W-1:0] w_bin_v;

   // prev resets high so a frame already running at release is not a start
   assign w_rise    = iFVAL & ~r_fval_prev;
   assign w_fall    = ~iFVAL & r_fval_prev;
   assign oIN_FRAME = (r_state == IN_FRAME);

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_end       = 1'b0;
      case (r_state)
         WAIT_FRAME: begin
            if (w_rise) begin
               w_state_nxt = IN_FRAME;
               w_start     = 1'b1;
            end
         end
         IN_FRAME: begin
            if (w_fall) begin
               w_state_nxt = WAIT_FRAME;
               w_end       = 1'b1;
            end
         end
         default: w_state_nxt = WAIT_FRAME;
      endcase
   end

   assign w_sum = SW'(r_pr) + SW'(r_pg) + SW'(r_pb) + SW'(128);
   assign w_luma_w = w_sum[SW-1:8];
   assign w_luma = (|w_luma_w[DATA_W+1:DATA_W]) ?
                   MAXV : w_luma_w[DATA_W-1:0];

   assign w_bin_v = (r_luma2 > r_thr_l) ? '0 : MAXV;

   always_comb begin
      w_r3 = r_r2;
      w_g3 = r_g2;
      w_b3 = r_b2;
      if (r_bin_l) begin
         w_r3 = w_bin_v;
         w_g3 = w_bin_v;
         w_b3 = w_bin_v;
      end else if (r_grey_l) begin
         w_r3 = r_luma2;
         w_g3 = r_luma2;
         w_b3 = r_luma2;
      end
   end

`ifdef RGB2GREY_AUTO_THRESH_EN
   localparam int AW = DATA_W + STAT_LOG2;

   logic [AW-1:0]      r_acc;
   logic [STAT_LOG2:0] r_cnt;
   logic [DATA_W-1:0]  r_auto_thr;
   logic               w_cnt_full;
   logic               w_unused_thresh;

   assign w_cnt_full      = r_cnt[STAT_LOG2];
   assign w_thr_act       = r_auto_thr;
   assign w_unused_thresh = ^iTHRESH;

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         r_acc      <= '0;
         r_cnt      <= '0;
         r_auto_thr <= THR_RST;
      end else if (w_start) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (r_state == IN_FRAME) begin
         if (w_end && w_cnt_full)
            r_auto_thr <= DATA_W'(r_acc >> STAT_LOG2);
         if (r_dv1 && !w_cnt_full) begin
            r_acc <= r_acc + AW'(w_luma);
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end
`else
   localparam int STAT_LOG2_UNUSED = STAT_LOG2;
   assign w_thr_act = iTHRESH;
`endif

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         r_state     <= WAIT_FRAME;
         r_fval_prev <= 1'b1;
         r_grey_l    <= 1'b0;
         r_bin_l     <= 1'b0;
         r_thr_l     <= THR_RST;
         oFRAME_CNT  <= '0;
         r_dv1       <= 1'b0;
         r_pr        <= '0;
         r_pg        <= '0;
         r_pb        <= '0;
         r_r1        <= '0;
         r_g1        <= '0;
         r_b1        <= '0;
         r_dv2       <= 1'b0;
         r_luma2     <= '0;
         r_r2        <= '0;
         r_g2        <= '0;
         r_b2        <= '0;
         oDVAL       <= 1'b0;
         oRed        <= '0;
         oGreen      <= '0;
         oBlue       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_fval_prev <= iFVAL;
         if (w_start) begin
            r_grey_l <= iGREY_SW;
            r_bin_l  <= iGREY_SW & iBIN_SW;
            r_thr_l  <= w_thr_act;
         end
         if (w_end)
            oFRAME_CNT <= oFRAME_CNT + 16'd1;

         r_dv1 <= iDVAL;
         if (iDVAL) begin
            r_pr <= PW'(iRed) * PW'(77);
            r_pg <= PW'(iGreen) * PW'(150);
            r_pb <= PW'(iBlue) * PW'(29);
            r_r1 <= iRed;
            r_g1 <= iGreen;
            r_b1 <= iBlue;
         end

         r_dv2 <= r_dv1;
         if (r_dv1) begin
            r_luma2 <= w_luma;
            r_r2    <= r_r1;
            r_g2    <= r_g1;
            r_b2    <= r_b1;
         end

         oDVAL <= r_dv2;
         if (r_dv2) begin
            oRed   <= w_r3;
            oGreen <= w_g3;
            oBlue  <= w_b3;
         end
      end
   end

endmodule
